// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates flush, multi-cycle EX holds and ID bubbles
// into a per-stage stall vector, and tracks a saturating stall-cycle counter.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_mc_req,
    input  logic [5:0]  ex_mc_len,
    input  logic        flush_req,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        ex_mc_busy,
    output logic        ex_mc_done,
    output logic [5:0]  mc_count,
    output logic [15:0] perf_stall_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Stall vector bit order: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;

    localparam logic [15:0] PERF_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic [5:0]  r_count;
    logic [15:0] r_perf;

    logic [1:0]  w_state_nxt;
    logic [5:0]  w_count_nxt;
    logic [5:0]  w_stall;
    logic        w_flush;

    // Next-state logic; flush overrides every state and leaves no pending run.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (flush_req) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_mc_req) begin
                        if (ex_mc_len >= 6'd2) begin
                            w_state_nxt = ST_RUN;
                            w_count_nxt = ex_mc_len - 6'd1;
                        end else begin
                            w_state_nxt = ST_DONE;
                            w_count_nxt = 6'd0;
                        end
                    end
                end
                ST_RUN: begin
                    if (!ex_mc_req) begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = 6'd0;
                    end else if (r_count == 6'd1) begin
                        w_state_nxt = ST_DONE;
                        w_count_nxt = 6'd0;
                    end else begin
                        w_count_nxt = r_count - 6'd1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = 6'd0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = 6'd0;
                end
            endcase
        end
    end

    // Hazard priority: flush > EX multi-cycle > ID bubble. DONE releases EX bits so the
    // pipeline advances in the same cycle the completion pulse reaches EX.
    always_comb begin
        w_stall = STALL_NONE;
        w_flush = 1'b0;
        if (rst) begin
            w_stall = STALL_NONE;
            w_flush = 1'b0;
        end else if (flush_req) begin
            w_flush = 1'b1;
        end else if (ex_mc_req && (r_state != ST_DONE)) begin
            w_stall = STALL_EX;
        end else if (stallreq_id) begin
            w_stall = STALL_ID;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= 6'd0;
            r_perf  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_stall[0] && (r_perf != PERF_MAX)) begin
                r_perf <= r_perf + 16'd1;
            end
        end
    end

    assign stall          = w_stall;
    assign flush          = w_flush;
    assign ex_mc_busy     = !rst && (r_state == ST_RUN);
    assign ex_mc_done     = !rst && !flush_req && (r_state == ST_DONE);
    assign mc_count       = rst ? 6'd0 : r_count;
    assign perf_stall_cnt = r_perf;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver predicts each cycle's outputs from an
// operation-level model and queues them; a monitor pops and compares every cycle.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0;
    logic        ex_mc_req = 1'b0;
    logic [5:0]  ex_mc_len = 6'd0;
    logic        flush_req = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_mc_busy;
    logic        ex_mc_done;
    logic [5:0]  mc_count;
    logic [15:0] perf_stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .ex_mc_req      (ex_mc_req),
        .ex_mc_len      (ex_mc_len),
        .flush_req      (flush_req),
        .stall          (stall),
        .flush          (flush),
        .ex_mc_busy     (ex_mc_busy),
        .ex_mc_done     (ex_mc_done),
        .mc_count       (mc_count),
        .perf_stall_cnt (perf_stall_cnt)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        busy;
        logic        done;
        logic [5:0]  mc_count;
        logic [15:0] perf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Operation model: an op occupies cycles 1..total after its request cycle;
    // cycles before total hold EX, cycle total is the completion cycle.
    bit m_in_op = 1'b0;
    int m_pos   = 0;
    int m_total = 0;
    int m_perf  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic q, input logic [5:0] l,
                        input logic f, input logic s);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ex_mc_req = q; ex_mc_len = l; flush_req = f; stallreq_id = s;
        e = '0;
        e.perf = m_perf[15:0];
        if (!r) begin
            e.flush    = f;
            e.done     = m_in_op && (m_pos == m_total) && !f;
            e.busy     = m_in_op && (m_pos < m_total);
            e.mc_count = e.busy ? 6'(m_total - m_pos) : 6'd0;
            if (f)
                e.stall = 6'b000000;
            else if (q && !(m_in_op && (m_pos == m_total)))
                e.stall = 6'b001111;
            else if (s)
                e.stall = 6'b000111;
        end
        exp_q.push_back(e);
        if (r) begin
            m_in_op = 1'b0;
            m_perf  = 0;
        end else begin
            if (e.stall[0] && (m_perf < 65535)) m_perf++;
            if (f) begin
                m_in_op = 1'b0;
            end else if (!m_in_op) begin
                if (q) begin
                    m_in_op = 1'b1;
                    m_pos   = 1;
                    m_total = (l < 6'd2) ? 1 : int'(l);
                end
            end else if (m_pos == m_total) begin
                m_in_op = 1'b0;
            end else if (!q) begin
                m_in_op = 1'b0;
            end else begin
                m_pos++;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",      32'(stall),          32'(e.stall));
                check("flush",      32'(flush),          32'(e.flush));
                check("ex_mc_busy", 32'(ex_mc_busy),     32'(e.busy));
                check("ex_mc_done", 32'(ex_mc_done),     32'(e.done));
                check("mc_count",   32'(mc_count),       32'(e.mc_count));
                check("perf",       32'(perf_stall_cnt), 32'(e.perf));
            end
        end
    end

    initial begin : driver
        logic       r, q, f, s;
        logic [5:0] l;

        repeat (2) step(1, 0, 6'd0, 0, 0);

        // len=4 run held until completion
        repeat (5) step(0, 1, 6'd4, 0, 0);
        step(0, 0, 6'd0, 0, 0);

        // len=0 single request
        step(0, 1, 6'd0, 0, 0);
        repeat (2) step(0, 0, 6'd0, 0, 0);

        // len=10 run flushed at cycle 5
        repeat (5) step(0, 1, 6'd10, 0, 0);
        step(0, 1, 6'd10, 1, 0);
        repeat (3) step(0, 0, 6'd0, 0, 0);

        // ID and EX together, then ID alone
        step(0, 1, 6'd5, 0, 1);
        repeat (3) step(0, 0, 6'd0, 0, 1);
        repeat (2) step(0, 0, 6'd0, 0, 0);

        // reset mid-run at mc_count=7, then no request
        repeat (4) step(0, 1, 6'd10, 0, 0);
        step(1, 1, 6'd10, 0, 0);
        repeat (12) step(0, 0, 6'd0, 0, 0);

        // randomized traffic that mostly follows the hold-until-done protocol
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 100) == 0;
            f = ($urandom % 40) == 0;
            s = ($urandom % 4) == 0;
            l = (($urandom % 20) == 0) ? 6'($urandom % 64) : 6'($urandom % 13);
            if (!m_in_op)
                q = ($urandom % 4) == 0;
            else if (m_pos == m_total)
                q = 1'($urandom % 2);
            else
                q = ($urandom % 30) != 0;
            step(r, q, l, f, s);
        end

        // long ID stall to saturate the perf counter
        step(1, 0, 6'd0, 0, 0);
        repeat (70000) step(0, 0, 6'd0, 0, 1);
        repeat (3) step(0, 0, 6'd0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("perf_saturated", 32'(perf_stall_cnt), 32'hFFFF);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have the following ports:
- clk  in  1  pipeline clock, all state updates on its rising edge
- rst  in  1  synchronous reset, 1 = `RstEnable`
- stallreq_id  in  1  decode load-use hazard, one-cycle bubble request (combinational from ID)
- ex_mc_req  in  1  EX holds a multi-cycle op (div/madd/msub); held high until ex_mc_done
- ex_mc_len  in  6  cycles the op needs, sampled only when a run starts
- flush_req  in  1  exception/annul request, highest priority
- stall  out  6  hold vector: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] reserved (always 0)
- flush  out  1  clear all pipeline registers this cycle
- ex_mc_busy  out  1  multi-cycle run in progress
- ex_mc_done  out  1  one-cycle completion pulse to EX
- mc_count  out  6  remaining cycles of the current run
- perf_stall_cnt  out  16  saturating count of cycles with stall[0]=1

Function
REQ-003 The block SHALL implement FSM states IDLE, RUN and DONE, with registers state, a 6-bit count and a 16-bit perf counter.
REQ-004 In IDLE with ex_mc_req=1, flush_req=0 and ex_mc_len>=2, the FSM SHALL go to RUN with count=ex_mc_len-1.
REQ-005 In IDLE with ex_mc_req=1, flush_req=0 and ex_mc_len in {0,1}, the FSM SHALL go to DONE with count=0.
REQ-006 In RUN, count SHALL decrement by 1 per cycle, and the FSM SHALL go to DONE on the edge where count==1, with count becoming 0.
REQ-007 DONE SHALL last exactly one cycle, SHALL assert ex_mc_done=1, and SHALL then go to IDLE unconditionally.
- The next multi-cycle run starts no earlier than the cycle after DONE.
REQ-008 If ex_mc_req=0 while in RUN, the FSM SHALL abort to IDLE with count=0 and no ex_mc_done pulse.
REQ-009 flush_req=1 in any state SHALL force next state IDLE and count=0, and SHALL suppress ex_mc_done in that cycle.
REQ-010 ex_mc_busy SHALL equal (state==RUN), and mc_count SHALL equal count; both are registered-state outputs.
REQ-011 stall and flush SHALL be combinational, with priority flush_req > EX > ID:
- flush_req=1 -> flush=1, stall=6'b000000
- else ex_mc_req=1 and state!=DONE -> stall=6'b001111
- else stallreq_id=1 -> stall=6'b000111
- else stall=6'b000000
REQ-012 In DONE, stall SHALL release EX-caused bits, so the pipeline advances in the same cycle as ex_mc_done.
- stallreq_id still applies in DONE.
REQ-013 perf_stall_cnt SHALL increment when stall[0]=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-014 stall[5] SHALL be 0 at all times.

Reset
REQ-015 With rst=1 at a rising edge, the block SHALL set state=IDLE, count=0 and perf_stall_cnt=0, regardless of any in-flight run.
REQ-016 While rst=1, all outputs SHALL be forced low: stall=0, flush=0, ex_mc_busy=0, ex_mc_done=0, mc_count=0.
REQ-017 The first cycle after rst deasserts SHALL behave as IDLE.
- A run resumes only if ex_mc_req is high in that cycle; a run interrupted by reset never produces ex_mc_done.

Verification
REQ-018 ex_mc_len=4, ex_mc_req held high from cycle 0 -> stall=001111 in cycles 0-3; ex_mc_busy=1 in cycles 1-3 with mc_count 3,2,1; ex_mc_done=1 and stall=000000 in cycle 4.
REQ-019 ex_mc_len=0, single request -> DONE in cycle 1, ex_mc_done pulses once, stall=001111 only in cycle 0.
REQ-020 ex_mc_len=10 run with flush_req=1 at cycle 5 -> flush=1, stall=0 that cycle; FSM IDLE next cycle; no ex_mc_done.
REQ-021 stallreq_id=1 and ex_mc_req=1 together -> stall=001111; with stallreq_id alone -> stall=000111 for exactly the cycles it is high.
REQ-022 rst=1 asserted mid-run (mc_count=7) -> all outputs 0 next cycle; with ex_mc_req=0 after reset, no ex_mc_done ever appears.
REQ-023 Hold stallreq_id=1 for 70000 cycles -> perf_stall_cnt reaches 16'hFFFF and remains there.
